// File: rtl/misr_bist_if.sv
// Host/CUT-side bundle for the MISR BIST controller.
// The master drives the session controls and the response stream; the slave reports status and signature.
interface misr_bist_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] golden;
  logic             abort;
  logic             resp_valid;
  logic             resp_bit;
  logic             cut_en;
  logic             busy;
  logic             done;
  logic             pass;
  logic             timeout;
  logic [WIDTH-1:0] signature;
  logic             sign;

  modport master (
    output start, golden, abort, resp_valid, resp_bit,
    input  cut_en, busy, done, pass, timeout, signature, sign
  );

  modport slave (
    input  start, golden, abort, resp_valid, resp_bit,
    output cut_en, busy, done, pass, timeout, signature, sign
  );
endinterface

// File: rtl/misr_bist_ctrl.sv
// BIST session controller: seeds a serial-input MISR, compacts N_PAT response bits,
// then compares against a golden signature and reports pass/fail/timeout.
module misr_bist_ctrl #(
  parameter int unsigned      WIDTH   = 16,
  parameter logic [WIDTH-1:0] TAPS    = 16'h002D,
  parameter int unsigned      SI_BIT  = 11,
  parameter logic [WIDTH-1:0] SEED    = 16'hFFFF,
  parameter int unsigned      N_PAT   = 1024,
  parameter int unsigned      TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  misr_bist_if.slave  bus
);

  localparam int unsigned CNT_W  = $clog2(N_PAT + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(N_PAT - 1);
  localparam logic [IDLE_W-1:0] LAST_IDLE = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEED_ST = 3'd1,
    RUN  = 3'd2,
    CMP  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   misr_q, misr_d, misr_step;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               cut_en_q, cut_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               tmo_q, tmo_d;
  logic               busy_now;

  // One MISR shift: feedback taps from the msb plus serial response injection.
  assign misr_step = {misr_q[WIDTH-2:0], 1'b0}
                   ^ (misr_q[WIDTH-1] ? TAPS : '0)
                   ^ (WIDTH'(bus.resp_bit) << SI_BIT);

  assign busy_now = (state_q == SEED_ST) || (state_q == RUN) || (state_q == CMP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      misr_q   <= SEED;
      cnt_q    <= '0;
      idle_q   <= '0;
      cut_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      misr_q   <= misr_d;
      cnt_q    <= cnt_d;
      idle_q   <= idle_d;
      cut_en_q <= cut_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    pass_d  = pass_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = SEED_ST;
      end
      SEED_ST: begin
        misr_d  = SEED;
        cnt_d   = '0;
        idle_d  = '0;
        pass_d  = 1'b0;
        tmo_d   = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        if (bus.resp_valid) begin
          misr_d = misr_step;
          cnt_d  = cnt_q + CNT_W'(1);
          idle_d = '0;
          if (cnt_q == LAST_CNT) state_d = CMP;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
          if ((TIMEOUT != 0) && (idle_q == LAST_IDLE)) begin
            state_d = DONE;
            tmo_d   = 1'b1;
            pass_d  = 1'b0;
          end
        end
      end
      CMP: begin
        pass_d  = (misr_q == bus.golden);
        tmo_d   = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        if (bus.start) begin
          state_d = SEED_ST;
          pass_d  = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything else in a busy state and freezes the MISR.
    if (bus.abort && busy_now) begin
      state_d = DONE;
      misr_d  = misr_q;
      cnt_d   = cnt_q;
      idle_d  = idle_q;
      pass_d  = 1'b0;
      tmo_d   = 1'b0;
    end

    cut_en_d = (state_d == RUN);
    busy_d   = (state_d == SEED_ST) || (state_d == RUN) || (state_d == CMP);
    done_d   = (state_d == DONE);
  end

  assign bus.cut_en    = cut_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.timeout   = tmo_q;
  assign bus.signature = misr_q;
  assign bus.sign      = misr_q[WIDTH-1];

endmodule

// File: tb/tb_misr_bist_ctrl.sv
// Directed bench for misr_bist_ctrl: a one-pattern instance for signature vectors and
// a default instance for long sessions, timeout, abort and reset corners.
module tb_misr_bist_ctrl;

  localparam logic [15:0] TB_TAPS = 16'h002D;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nfail;

  misr_bist_if #(.WIDTH(16)) sb ();
  misr_bist_if #(.WIDTH(16)) bb ();

  misr_bist_ctrl #(.N_PAT(1), .TIMEOUT(255)) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sb)
  );

  misr_bist_ctrl #(.N_PAT(1024), .TIMEOUT(255)) u_big (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rb;
    logic [15:0] gold;
    logic [15:0] exp_sig;
    logic        exp_pass;
  } vec_t;

  vec_t tbl [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Independent bitwise MISR reference: bit0 takes the msb, tapped stages xor it in.
  function automatic logic [15:0] misr_model(input logic [15:0] s, input logic b);
    logic [15:0] n;
    logic        m;
    m = s[15];
    n[0] = m;
    for (int i = 1; i < 16; i++) n[i] = s[i-1] ^ (TB_TAPS[i] & m);
    n[11] = n[11] ^ b;
    return n;
  endfunction

  // Waits for done on the big instance, counting edges and cut_en cycles.
  task automatic wait_big(input int limit, inout int edges, output int cuts);
    cuts = 0;
    while (!bb.done && edges < limit) begin
      tick();
      edges++;
      if (bb.cut_en) cuts++;
    end
  endtask

  initial begin
    int          edges;
    int          cuts;
    logic [15:0] exp_sig;
    logic        exp_msb;

    nvec  = 0;
    nfail = 0;
    tbl[0] = '{rb: 1'b0, gold: 16'hFFD3, exp_sig: 16'hFFD3, exp_pass: 1'b1};
    tbl[1] = '{rb: 1'b1, gold: 16'hFFD3, exp_sig: 16'hF7D3, exp_pass: 1'b0};
    tbl[2] = '{rb: 1'b1, gold: 16'hF7D3, exp_sig: 16'hF7D3, exp_pass: 1'b1};
    tbl[3] = '{rb: 1'b0, gold: 16'h0000, exp_sig: 16'hFFD3, exp_pass: 1'b0};

    sb.start = 1'b0; sb.golden = '0; sb.abort = 1'b0; sb.resp_valid = 1'b0; sb.resp_bit = 1'b0;
    bb.start = 1'b0; bb.golden = '0; bb.abort = 1'b0; bb.resp_valid = 1'b0; bb.resp_bit = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    chk("rst_sig", 32'(sb.signature), 32'h0000FFFF);
    chk("rst_sign", 32'(sb.sign), 32'd1);
    chk("rst_flags", 32'({bb.busy, bb.done, bb.cut_en, bb.pass, bb.timeout}), 32'd0);

    // Abort and resp_valid in IDLE must be ignored.
    sb.abort = 1'b1; sb.resp_valid = 1'b1;
    tick();
    tick();
    chk("idle_abort_flags", 32'({sb.busy, sb.done, sb.cut_en}), 32'd0);
    chk("idle_sig_hold", 32'(sb.signature), 32'h0000FFFF);
    sb.abort = 1'b0;

    // One-pattern sessions from the vector table.
    for (int i = 0; i < 4; i++) begin
      sb.resp_valid = 1'b1;
      sb.resp_bit   = tbl[i].rb;
      sb.golden     = tbl[i].gold;
      sb.start      = 1'b1;
      tick();
      sb.start = 1'b0;
      edges = 1;
      while (!sb.done && edges < 16) begin
        tick();
        edges++;
      end
      exp_sig = tbl[i].exp_sig;
      exp_msb = exp_sig[15];
      chk($sformatf("v%0d_latency", i), 32'(edges), 32'd4);
      chk($sformatf("v%0d_sig", i), 32'(sb.signature), 32'(exp_sig));
      chk($sformatf("v%0d_pass", i), 32'(sb.pass), 32'(tbl[i].exp_pass));
      chk($sformatf("v%0d_timeout", i), 32'(sb.timeout), 32'd0);
      chk($sformatf("v%0d_sign", i), 32'(sb.sign), 32'(exp_msb));
      tick();
      chk($sformatf("v%0d_done_hold", i), 32'({sb.done, sb.busy}), 32'b10);
      chk($sformatf("v%0d_sig_hold", i), 32'(sb.signature), 32'(exp_sig));
    end
    sb.resp_valid = 1'b0;

    // Full 1024-bit session with resp_valid held high.
    exp_sig = 16'hFFFF;
    for (int k = 0; k < 1024; k++) exp_sig = misr_model(exp_sig, 1'b0);
    bb.golden = exp_sig; bb.resp_bit = 1'b0; bb.resp_valid = 1'b1; bb.start = 1'b1;
    tick();
    bb.start = 1'b0;
    edges = 1;
    wait_big(2000, edges, cuts);
    chk("full_latency", 32'(edges), 32'd1027);
    chk("full_cut_en_cycles", 32'(cuts), 32'd1024);
    chk("full_sig", 32'(bb.signature), 32'(exp_sig));
    chk("full_pass", 32'({bb.done, bb.pass, bb.timeout}), 32'b110);

    // Abort together with start mid-RUN after three compacted ones.
    bb.resp_bit = 1'b1; bb.start = 1'b1;
    tick();
    bb.start = 1'b0;
    tick();
    chk("abort_run_cut_en", 32'({bb.cut_en, bb.busy, bb.pass}), 32'b110);
    tick(); tick(); tick();
    exp_sig = 16'hFFFF;
    for (int k = 0; k < 3; k++) exp_sig = misr_model(exp_sig, 1'b1);
    bb.abort = 1'b1; bb.start = 1'b1;
    tick();
    bb.abort = 1'b0; bb.start = 1'b0;
    chk("abort_flags", 32'({bb.done, bb.busy, bb.cut_en, bb.pass, bb.timeout}), 32'b10000);
    chk("abort_sig", 32'(bb.signature), 32'(exp_sig));
    tick();
    chk("abort_sig_hold", 32'(bb.signature), 32'(exp_sig));
    chk("abort_done_hold", 32'(bb.done), 32'd1);

    // Timeout with resp_valid stuck low.
    bb.resp_valid = 1'b0; bb.start = 1'b1;
    tick();
    bb.start = 1'b0;
    edges = 1;
    wait_big(600, edges, cuts);
    chk("tmo_latency", 32'(edges), 32'd257);
    chk("tmo_flags", 32'({bb.done, bb.timeout, bb.pass}), 32'b110);
    chk("tmo_sig", 32'(bb.signature), 32'h0000FFFF);

    // A single valid bit restarts the idle count.
    bb.resp_bit = 1'b0; bb.start = 1'b1;
    tick();
    bb.start = 1'b0;
    edges = 1;
    tick();
    edges++;
    for (int k = 0; k < 200; k++) begin
      tick();
      edges++;
    end
    chk("tmo2_still_busy", 32'({bb.busy, bb.done}), 32'b10);
    bb.resp_valid = 1'b1;
    tick();
    edges++;
    bb.resp_valid = 1'b0;
    wait_big(1000, edges, cuts);
    chk("tmo2_latency", 32'(edges), 32'd458);
    chk("tmo2_flags", 32'({bb.done, bb.timeout, bb.pass}), 32'b110);
    chk("tmo2_sig", 32'(bb.signature), 32'h0000FFD3);

    // Reset in the middle of RUN.
    bb.resp_valid = 1'b1; bb.resp_bit = 1'b1; bb.start = 1'b1;
    tick();
    bb.start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_flags", 32'({bb.busy, bb.done, bb.cut_en, bb.pass, bb.timeout}), 32'd0);
    chk("midrst_sig", 32'(bb.signature), 32'h0000FFFF);
    chk("midrst_small_done", 32'(sb.done), 32'd0);

    // Clean session after reset.
    exp_sig = 16'hFFFF;
    for (int k = 0; k < 1024; k++) exp_sig = misr_model(exp_sig, 1'b1);
    bb.golden = exp_sig; bb.start = 1'b1;
    tick();
    bb.start = 1'b0;
    edges = 1;
    wait_big(2000, edges, cuts);
    chk("clean_latency", 32'(edges), 32'd1027);
    chk("clean_sig", 32'(bb.signature), 32'(exp_sig));
    chk("clean_pass", 32'({bb.done, bb.pass, bb.timeout}), 32'b110);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
